// File: rtl/mesi_pkg.sv
// Shared types and constants for the external-memory arbiter and its round-robin grant logic.
package mesi_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] RESP_OKAY = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_t;

    // Build a {err, done} response word.
    function automatic logic [1:0] mk_resp(input logic err);
        return err ? RESP_ERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after last_grant+1 (mod NUM_PORTS), one-hot result.
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant_oh,
    output logic                 any_req
);

    logic found_s;
    int   ptr_s;

    // Rotated priority search starting just after the previous winner.
    always_comb begin
        grant_oh = '0;
        found_s  = 1'b0;
        ptr_s    = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            ptr_s           = (int'(last_grant) + k) % NUM_PORTS;
            grant_oh[ptr_s] = grant_oh[ptr_s] | (req[ptr_s] & ~found_s);
            found_s         = found_s | req[ptr_s];
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/ext_mem_arbiter.sv
// Serialises per-cache request pulses onto a single memory port and routes responses back.
// Optional WAIT timeout enabled by defining ARB_TIMEOUT_EN.
module ext_mem_arbiter
    import mesi_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_PORTS*ADDR_W-1:0] s_data_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] s_wdata,
    input  logic [NUM_PORTS-1:0]        s_awvalid,
    input  logic [NUM_PORTS-1:0]        s_wvalid,
    input  logic [NUM_PORTS-1:0]        s_arvalid,
    output logic [NUM_PORTS-1:0]        s_rvalid,
    output logic [NUM_PORTS*DATA_W-1:0] s_rdata,
    output logic [2*NUM_PORTS-1:0]      s_w_resp,
    output logic [2*NUM_PORTS-1:0]      s_r_resp,
    output logic [ADDR_W-1:0]           m_data_addr,
    output logic [DATA_W-1:0]           m_wdata,
    output logic                        m_awvalid,
    output logic                        m_wvalid,
    output logic                        m_arvalid,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic [1:0]                  m_w_resp,
    input  logic [1:0]                  m_r_resp,
    output logic                        busy,
    output logic [NUM_PORTS-1:0]        drop
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t state_r, state_s;
    logic [NUM_PORTS-1:0] pend_r, pend_wr_r, drop_r;
    logic [ADDR_W-1:0]    addr_lat_r [NUM_PORTS];
    logic [DATA_W-1:0]    data_lat_r [NUM_PORTS];
    logic [IDX_W-1:0]     grant_r, grant_s, last_grant_r, last_grant_s, grant_idx_s;
    logic                 cur_wr_r, cur_wr_s;
    logic [NUM_PORTS-1:0] clr_s, port_busy_s, cap_wr_s, cap_rd_s, drop_evt_s, grant_oh_s;
    logic                 any_pend_s, wr_done_s, rd_done_s, timeout_s;

    logic [ADDR_W-1:0]           m_addr_s;
    logic [DATA_W-1:0]           m_wdata_s;
    logic                        m_awvalid_s, m_arvalid_s;
    logic [NUM_PORTS-1:0]        s_rvalid_s;
    logic [NUM_PORTS*DATA_W-1:0] s_rdata_s;
    logic [2*NUM_PORTS-1:0]      s_w_resp_s, s_r_resp_s;
    logic                        m_awvalid_r, m_arvalid_r, busy_r;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rr (
        .req       (pend_r),
        .last_grant(last_grant_r),
        .grant_oh  (grant_oh_s),
        .any_req   (any_pend_s)
    );

    // Request classification; the port in its RESP cycle may accept a fresh pulse.
    always_comb begin
        clr_s       = '0;
        port_busy_s = '0;
        cap_wr_s    = '0;
        cap_rd_s    = '0;
        drop_evt_s  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            clr_s[i]       = (state_r == ST_RESP) && (grant_r == IDX_W'(i));
            port_busy_s[i] = pend_r[i] && !clr_s[i];
            cap_wr_s[i]    = !port_busy_s[i] && s_awvalid[i] && s_wvalid[i];
            cap_rd_s[i]    = !port_busy_s[i] && s_arvalid[i] && !(s_awvalid[i] && s_wvalid[i]);
            drop_evt_s[i]  = port_busy_s[i]
                ? (s_awvalid[i] | s_wvalid[i] | s_arvalid[i])
                : ((s_awvalid[i] & s_wvalid[i] & s_arvalid[i]) | (s_awvalid[i] ^ s_wvalid[i]));
        end
    end

    // Per-port pending flags, request latches and sticky drop flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_r    <= '0;
            pend_wr_r <= '0;
            drop_r    <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                addr_lat_r[i] <= '0;
                data_lat_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (cap_wr_s[i]) begin
                    pend_r[i]     <= 1'b1;
                    pend_wr_r[i]  <= 1'b1;
                    addr_lat_r[i] <= s_data_addr[i*ADDR_W +: ADDR_W];
                    data_lat_r[i] <= s_wdata[i*DATA_W +: DATA_W];
                end else if (cap_rd_s[i]) begin
                    pend_r[i]     <= 1'b1;
                    pend_wr_r[i]  <= 1'b0;
                    addr_lat_r[i] <= s_data_addr[i*ADDR_W +: ADDR_W];
                end else if (clr_s[i]) begin
                    pend_r[i]     <= 1'b0;
                end
            end
            drop_r <= drop_r | drop_evt_s;
        end
    end

    // One-hot grant to binary index.
    always_comb begin
        grant_idx_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_idx_s = grant_idx_s | (grant_oh_s[i] ? IDX_W'(i) : '0);
        end
    end

    assign wr_done_s = cur_wr_r && m_w_resp[0];
    assign rd_done_s = !cur_wr_r && m_r_resp[0];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_r;

    assign timeout_s = (state_r == ST_WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT-cycle counter, restarted for every issued transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_r <= '0;
        end else if (state_s == ST_ISSUE) begin
            wait_cnt_r <= '0;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next state plus next values of every registered output.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        cur_wr_s     = cur_wr_r;
        m_addr_s     = m_data_addr;
        m_wdata_s    = m_wdata;
        m_awvalid_s  = 1'b0;
        m_arvalid_s  = 1'b0;
        s_rvalid_s   = '0;
        s_rdata_s    = '0;
        s_w_resp_s   = '0;
        s_r_resp_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (any_pend_s) begin
                    state_s     = ST_ISSUE;
                    grant_s     = grant_idx_s;
                    cur_wr_s    = pend_wr_r[grant_idx_s];
                    m_addr_s    = addr_lat_r[grant_idx_s];
                    m_wdata_s   = data_lat_r[grant_idx_s];
                    m_awvalid_s = pend_wr_r[grant_idx_s];
                    m_arvalid_s = !pend_wr_r[grant_idx_s];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_done_s || rd_done_s || timeout_s) begin
                    state_s = ST_RESP;
                    if (cur_wr_r) begin
                        s_w_resp_s[2*int'(grant_r) +: 2] = wr_done_s ? mk_resp(m_w_resp[1]) : RESP_ERR;
                    end else begin
                        s_r_resp_s[2*int'(grant_r) +: 2]      = rd_done_s ? mk_resp(m_r_resp[1]) : RESP_ERR;
                        s_rvalid_s[grant_r]                   = 1'b1;
                        s_rdata_s[int'(grant_r)*DATA_W +: DATA_W] = rd_done_s ? m_rdata : '0;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s      = ST_IDLE;
                last_grant_s = grant_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= IDX_W'(NUM_PORTS - 1);
            cur_wr_r     <= 1'b0;
            m_data_addr  <= '0;
            m_wdata      <= '0;
            m_awvalid_r  <= 1'b0;
            m_arvalid_r  <= 1'b0;
            s_rvalid     <= '0;
            s_rdata      <= '0;
            s_w_resp     <= '0;
            s_r_resp     <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            cur_wr_r     <= cur_wr_s;
            m_data_addr  <= m_addr_s;
            m_wdata      <= m_wdata_s;
            m_awvalid_r  <= m_awvalid_s;
            m_arvalid_r  <= m_arvalid_s;
            s_rvalid     <= s_rvalid_s;
            s_rdata      <= s_rdata_s;
            s_w_resp     <= s_w_resp_s;
            s_r_resp     <= s_r_resp_s;
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign m_awvalid = m_awvalid_r;
    assign m_wvalid  = m_awvalid_r;
    assign m_arvalid = m_arvalid_r;
    assign busy      = busy_r;
    assign drop      = drop_r;

endmodule

// File: doc/ext_mem_arbiter.md
Name: ext_mem_arbiter

Overview:
- Round-robin arbiter that shares one external memory port between NUM_PORTS mesi_coherency cache instances, one at a time.
- Sits between each cache's ext_* bus and the single memory model/controller.
- Captures single-cycle request pulses from each cache and serialises them onto the memory port, one outstanding transaction at a time.
- Routes the memory's write or read response back to the originating cache.

Parameters:
- NUM_PORTS, 2, number of cache requesters (2..8).
- ADDR_W, 20, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, cycles to wait in WAIT before a timeout error (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- s_data_addr  in  NUM_PORTS*ADDR_W  per-port request address; port i occupies slice [i*ADDR_W +: ADDR_W].
- s_wdata  in  NUM_PORTS*DATA_W  per-port write data.
- s_awvalid, s_wvalid, s_arvalid  in  NUM_PORTS  per-port request pulses.
- s_rvalid  out  NUM_PORTS  one-cycle pulse with a read response.
- s_rdata  out  NUM_PORTS*DATA_W  read data; valid while s_rvalid is high.
- s_w_resp, s_r_resp  out  2*NUM_PORTS  per-port {err, done}.
- m_data_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_awvalid, m_wvalid, m_arvalid  out  1  memory request pulses.
- m_rdata  in  DATA_W  memory read data.
- m_w_resp, m_r_resp  in  2  memory response {err, done}.
- busy  out  1  high whenever the FSM is not in IDLE.
- drop  out  NUM_PORTS  sticky per-port flag: a request pulse was discarded.

Behaviour:
- Capture, per port, on a rising edge:
  - s_awvalid & s_wvalid → pending write; addr and data latched.
  - else s_arvalid → pending read; addr latched.
  - Write wins if both are present; the read is discarded and sets drop[i].
  - s_awvalid without s_wvalid, or s_wvalid without s_awvalid, is discarded and sets drop[i].
  - A pulse while port i is pending or being served is discarded and sets drop[i].
  - Exception: a pulse in the RESP cycle of port i is accepted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any port is pending, grant the first pending port searching from last_grant+1 modulo NUM_PORTS; go to ISSUE.
  - A request captured on edge k is eligible on edge k+1.
- ISSUE:
  - For exactly one cycle, drive m_data_addr and m_wdata from the granted port's latch.
  - Drive m_awvalid=m_wvalid=1 for a write, or m_arvalid=1 for a read.
  - Go to WAIT.
- WAIT:
  - Write: complete when m_w_resp[0]=1.
  - Read: complete when m_r_resp[0]=1; latch m_rdata.
  - Latch the err bit ([1]); go to RESP.
  - A response of the wrong type is ignored.
  - A response arriving during ISSUE is ignored; memory latency is at least 1 cycle.
- RESP:
  - For one cycle, drive the granted port's s_w_resp or s_r_resp = {err,1'b1}.
  - For a read, also drive s_rvalid[i]=1 and s_rdata slice = latched data.
  - Clear pending[i]; last_grant=i; go to IDLE.
- Minimum latency: request pulse at edge 0 → m_*valid in cycle 2 → response to the cache 1 cycle after the memory's done.
- Outputs not granted, or outside the listed states, are 0.
- m_data_addr and m_wdata hold their last value; they are 0 after reset.
- Reset, including mid-transaction:
  - state=IDLE; pending, drop, all valid and resp outputs =0; rdata=0.
  - last_grant=NUM_PORTS-1, so port 0 wins first.
  - An in-flight memory response arriving after reset is ignored.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter counts up in WAIT.
  - If it reaches TIMEOUT_CYCLES without done, go to RESP with err=1, i.e. response 2'b11 and s_rdata=0.
  - The counter clears on entry to ISSUE.
- Undefined: no counter; WAIT holds indefinitely until done.

Decomposition:
- Shared package mesi_pkg:
  - RESP_OKAY=2'b01, RESP_ERR=2'b11.
  - FSM state encodings.
  - ADDR_W and DATA_W defaults.
- Sub-module rr_arbiter (pending vector + last_grant → one-hot grant): combinational rotate and priority search, instantiated once.

Test Plan:
- Single write: port0 write 0x00010 / 0xDEADBEEF, memory done after 3 cycles → m_awvalid pulses once with that addr/data; s_w_resp[1:0]=2'b01 exactly one cycle; busy returns to 0.
- Simultaneous requests: ports 0 and 1 read 0x00100 and 0x00200 on the same edge → memory sees 0x00100 first, then 0x00200; port0 s_rdata=0x11111111, port1 s_rdata=0x22222222.
- Fairness:
  - Both ports keep re-requesting immediately in their RESP cycle for 8 transactions.
  - Grants alternate 0,1,0,1…; drop stays 0.
- Drop:
  - Port1 pulses a second write while its first is in WAIT → drop[1]=1, only one memory write issued.
  - Both s_awvalid and s_arvalid pulsed on port0 → write issued, drop[0]=1.
- Error and reset:
  - Memory returns m_r_resp=2'b11 → port gets s_r_resp=2'b11.
  - rstn low during WAIT → all outputs 0; a later memory done produces no response.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64), memory never responds → s_w_resp=2'b11 exactly 64 cycles after WAIT entry; the next pending port is then served.
